// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared page/row/column bus. Grants one master at
// a time, follows the Start/lower-address/dValid handshake to hold the grant
// for a whole transaction, and reclaims the bus with two watchdogs.
module bus_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int GRANT_TIMEOUT = 8,
  parameter int XFER_TIMEOUT  = 20,
  parameter int IDW           = $clog2(NUM_MASTERS)
) (
  input  logic                   b_Clock,
  input  logic                   b_Reset_L,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] gnt,
  input  logic                   b_Start_L,
  input  logic                   b_re_L,
  input  logic                   b_dValid_L,
  output logic [IDW-1:0]         owner,
  output logic                   bus_busy,
  output logic                   xfer_rd,
  output logic                   xfer_done,
  output logic                   timeout_err
);

  localparam int TMAX = (GRANT_TIMEOUT > XFER_TIMEOUT) ? GRANT_TIMEOUT : XFER_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] GNT_LAST = CW'(GRANT_TIMEOUT - 1);
  localparam logic [CW-1:0] XFR_LAST = CW'(XFER_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, GRANT, ADDR, DATA, TURN} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]         owner_q, owner_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   busy_q, busy_d;
  logic                   xfer_rd_q, xfer_rd_d;
  logic                   done_q, done_d;
  logic                   tmo_q, tmo_d;
  logic [IDW-1:0]         win, cand;

  // Round-robin pick: first requester after the last owner. Scanning offsets
  // from farthest to nearest lets the nearest one overwrite the result.
  always_comb begin
    win  = owner_q;
    cand = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = IDW'((int'(owner_q) + i) % NUM_MASTERS);
      if (req[cand]) win = cand;
    end
  end

  // Saturating watchdog counter increment.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    xfer_rd_d = xfer_rd_q;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Rogue Start strobes here are simply not looked at.
        if (|req) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          owner_d    = win;
          cnt_d      = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        cnt_d = cnt_inc;
        if (!b_Start_L) begin
          xfer_rd_d = ~b_re_L;
          cnt_d     = '0;
          state_d   = ADDR;
        end else if (!req[owner_q]) begin
          gnt_d   = '0;
          state_d = TURN;
        end else if (cnt_q == GNT_LAST) begin
          gnt_d   = '0;
          tmo_d   = 1'b1;
          state_d = TURN;
        end
      end
      ADDR: begin
        // Master bounds the upper-address phase; Start high marks lower address.
        if (b_Start_L) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_inc;
        if (!b_dValid_L) begin
          gnt_d   = '0;
          done_d  = 1'b1;
          state_d = TURN;
        end else if (cnt_q == XFR_LAST) begin
          gnt_d   = '0;
          tmo_d   = 1'b1;
          state_d = TURN;
        end
      end
      TURN: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; owner resets to the top index so master 0 wins first.
  always_ff @(posedge b_Clock or negedge b_Reset_L) begin
    if (!b_Reset_L) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= IDW'(NUM_MASTERS - 1);
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      xfer_rd_q <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      xfer_rd_q <= xfer_rd_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
    end
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign bus_busy    = busy_q;
  assign xfer_rd     = xfer_rd_q;
  assign xfer_done   = done_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed bus transactions with a grant scoreboard.
module tb_bus_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         start_l, re_l, dv_l;
  logic [1:0]   owner;
  logic         busy, xrd, done, tmo;

  int checks = 0;
  int errs   = 0;
  int exp_q[$];
  logic [N-1:0] gnt_prev = '0;

  bus_arbiter #(.NUM_MASTERS(N), .GRANT_TIMEOUT(8), .XFER_TIMEOUT(20)) dut (
    .b_Clock(clk), .b_Reset_L(rst_n), .req(req), .gnt(gnt),
    .b_Start_L(start_l), .b_re_L(re_l), .b_dValid_L(dv_l),
    .owner(owner), .bus_busy(busy), .xfer_rd(xrd),
    .xfer_done(done), .timeout_err(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Scoreboard: every rising grant must match the next expected winner.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
      if (gnt != '0 && gnt_prev == '0) begin
        if (exp_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
        else begin
          int m;
          m = exp_q.pop_front();
          chk("sb_gnt", 32'(gnt), 32'(1 << m));
          chk("sb_owner", 32'(owner), 32'(m));
        end
      end
    end
    gnt_prev <= gnt;
  end

  task automatic do_reset();
    rst_n = 1'b0; req = '0; start_l = 1'b1; re_l = 1'b1; dv_l = 1'b1;
    step(); step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_owner", 32'(owner), 3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {29'd0, xrd, done, tmo}, 0);
    rst_n = 1'b1;
    step();
  endtask

  // Runs a transaction for master m, entered just after its grant edge.
  task automatic do_xfer(input int m, input bit rd, input int addr_cyc, input int dv_wait);
    start_l = 1'b0; re_l = ~rd;
    repeat (addr_cyc) step();
    start_l = 1'b1; re_l = 1'b1;
    step();
    chk("data_gnt", 32'(gnt), 32'(1 << m));
    repeat (dv_wait) step();
    dv_l = 1'b0;
    step();
    chk("turn_done", 32'(done), 1);
    chk("turn_tmo", 32'(tmo), 0);
    chk("turn_gnt", 32'(gnt), 0);
    chk("turn_owner", 32'(owner), 32'(m));
    chk("turn_xrd", 32'(xrd), 32'(rd));
    dv_l = 1'b1; req[m] = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    do_reset();

    // Single write by master 0; grant one edge after req.
    req = 4'b0001; exp_q.push_back(0);
    step();
    chk("t1_gnt", 32'(gnt), 1);
    chk("t1_busy", 32'(busy), 1);
    do_xfer(0, 1'b0, 3, 1);

    // Rogue Start while idle is ignored.
    start_l = 1'b0;
    step(); step();
    chk("rogue_busy", 32'(busy), 0);
    chk("rogue_gnt", 32'(gnt), 0);
    chk("rogue_tmo", 32'(tmo), 0);
    start_l = 1'b1;

    // All masters requesting: order 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) exp_q.push_back(k % 4);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_owner", 32'(owner), 32'(k % 4));
      do_xfer(k % 4, 1'b1, 1, 0);
      req[k % 4] = 1'b1;
    end
    req = '0;
    step(); step();

    // Master 2 never starts: grant watchdog after 8 GRANT cycles, then master 3.
    do_reset();
    req = 4'b1100; exp_q.push_back(2); exp_q.push_back(3);
    step();
    chk("gto_gnt", 32'(gnt), 32'h4);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("gto_hold", {30'd0, tmo, gnt == 4'b0100}, 1);
    end
    step();
    chk("gto_tmo", 32'(tmo), 1);
    chk("gto_drop", 32'(gnt), 0);
    req[2] = 1'b0;
    step();
    chk("gto_idle", 32'(gnt), 0);
    chk("gto_pulse", 32'(tmo), 0);
    step();
    chk("gto_next", 32'(gnt), 32'h8);
    do_xfer(3, 1'b1, 1, 0);

    // Read with no dValid: transfer watchdog after 20 DATA cycles.
    req = 4'b0001; exp_q.push_back(0);
    step();
    start_l = 1'b0; re_l = 1'b0;
    step();
    start_l = 1'b1; re_l = 1'b1;
    step();
    for (int i = 1; i < 20; i++) begin
      step();
      chk("xto_hold", {30'd0, tmo, gnt == 4'b0001}, 1);
    end
    step();
    chk("xto_tmo", 32'(tmo), 1);
    chk("xto_done", 32'(done), 0);
    chk("xto_gnt", 32'(gnt), 0);
    chk("xto_xrd", 32'(xrd), 1);
    req = '0;
    step();

    // dValid on the expiry cycle: completion wins.
    req = 4'b0010; exp_q.push_back(1);
    step();
    do_xfer(1, 1'b1, 1, 19);

    // Reset mid-DATA drops everything asynchronously.
    req = 4'b0100; exp_q.push_back(2); exp_q.push_back(2);
    step();
    start_l = 1'b0;
    step();
    start_l = 1'b1;
    step();
    chk("ar_pre", 32'(gnt), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_owner", 32'(owner), 3);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_regnt", 32'(gnt), 32'h4);
    do_xfer(2, 1'b0, 1, 0);

    step();
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end
endmodule
